// File: rtl/matrix_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_mem_sequencer
// Purpose  : Moves two DIM x DIM signed matrices from a shared single-port
//            memory into the ALU, waits for the ALU to finish and writes the
//            result matrix back to memory. Start/busy/done handshake toward
//            the control logic, pipelined reads with MEM_LAT cycles latency.
// Ports    : clk, reset             clock, synchronous active-high reset
//            start, op_code         request pulse (IDLE only), operation code
//            busy, done             activity flag, one-cycle completion pulse
//            error, overflow        sticky ALU timeout flag, latched overflow
//            mem_addr/we/wdata      memory request side
//            mem_rdata              read data, MEM_LAT cycles after address
//            alu_op/a/b/start       operands and one-cycle kick to the ALU
//            alu_done/overflow/result  ALU completion, flag and result
// Options  : `define MATSEQ_TIMEOUT_EN enables the ALU wait timeout (TIMEOUT
//            cycles); without it ALU_WAIT waits forever and error stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_mem_sequencer #(
  parameter int DATA_W   = 8,
  parameter int DIM      = 5,
  parameter int ADDR_W   = 7,
  parameter int MEM_LAT  = 1,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 op_code,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       overflow,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_we,
  output logic [2*DATA_W-1:0]        mem_wdata,
  input  logic [2*DATA_W-1:0]        mem_rdata,
  output logic [2:0]                 alu_op,
  output logic [DIM*DIM*DATA_W-1:0]  alu_a,
  output logic [DIM*DIM*DATA_W-1:0]  alu_b,
  output logic                       alu_start,
  input  logic                       alu_done,
  input  logic                       alu_overflow,
  input  logic [DIM*DIM*DATA_W-1:0]  alu_result
);

  localparam int                 c_N      = DIM * DIM;
  localparam int                 c_CNT_W  = $clog2(c_N + 1);
  localparam int                 c_TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(c_N - 1);
  localparam logic [c_CNT_W-1:0] c_N_CNT  = c_CNT_W'(c_N);
  localparam logic [ADDR_W-1:0]  c_SRC    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0]  c_DST    = ADDR_W'(DST_BASE);
  localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT - 1);

`ifdef MATSEQ_TIMEOUT_EN
  localparam logic c_TIMEOUT_EN = 1'b1;
`else
  // Timeout compare is constant-false, so r_wait/r_error fold to constants
  // and error reads as 0.
  localparam logic c_TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_ALU_START = 3'd2,
    S_ALU_WAIT  = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [c_CNT_W-1:0]     r_issue_cnt;   // reads issued (k)
  logic [c_CNT_W-1:0]     r_cap_cnt;     // read data captured (j)
  logic [c_CNT_W-1:0]     r_wr_cnt;      // result elements written (i)
  logic [MEM_LAT-1:0]     r_vld;         // in-flight read tracker
  logic [c_TO_W-1:0]      r_wait;
  logic [c_N*DATA_W-1:0]  r_a;
  logic [c_N*DATA_W-1:0]  r_b;
  logic [c_N*DATA_W-1:0]  r_result;
  logic [2:0]             r_op;
  logic                   r_error;
  logic                   r_overflow;

  logic                   w_issue;
  logic                   w_capture;
  logic                   w_timeout;

  assign w_issue   = (r_state == S_READ) && (r_issue_cnt < c_N_CNT);
  // The oldest stage of the tracker marks the cycle its read data arrives.
  assign w_capture = (r_state == S_READ) && r_vld[MEM_LAT-1];
  assign w_timeout = c_TIMEOUT_EN && (r_state == S_ALU_WAIT) && !alu_done &&
                     (r_wait == c_TO_LAST);

  assign alu_op   = r_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign error    = r_error;
  assign overflow = r_overflow;

  // --------------------------------------------------------------------------
  // Read-valid shift register, one stage per cycle of memory latency
  // --------------------------------------------------------------------------
  generate
    if (MEM_LAT == 1) begin : g_vld_single
      always_ff @(posedge clk) begin
        if (reset) r_vld <= '0;
        else       r_vld <= w_issue;
      end
    end else begin : g_vld_chain
      always_ff @(posedge clk) begin
        if (reset) r_vld <= '0;
        else       r_vld <= {r_vld[MEM_LAT-2:0], w_issue};
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next state and Moore-style outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        if (w_issue) mem_addr = c_SRC + ADDR_W'(r_issue_cnt);
        // Last capture happens in the final READ cycle (N + MEM_LAT total).
        if (w_capture && (r_cap_cnt == c_LAST)) w_next = S_ALU_START;
      end
      S_ALU_START: begin
        alu_start = 1'b1;
        w_next    = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (alu_done)       w_next = S_WRITE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = c_DST + ADDR_W'(r_wr_cnt);
        mem_wdata = {{DATA_W{1'b0}}, r_result[r_wr_cnt*DATA_W +: DATA_W]};
        if (r_wr_cnt == c_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, operand matrices, result buffer, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_wait      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_op        <= '0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op        <= op_code;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_wait      <= '0;
          end
        end
        S_READ: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (w_capture) begin
            r_a[r_cap_cnt*DATA_W +: DATA_W] <= mem_rdata[DATA_W-1:0];
            r_b[r_cap_cnt*DATA_W +: DATA_W] <= mem_rdata[2*DATA_W-1:DATA_W];
            r_cap_cnt <= r_cap_cnt + 1'b1;
          end
        end
        S_ALU_WAIT: begin
          if (alu_done) begin
            r_result   <= alu_result;
            r_overflow <= alu_overflow;
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITE: begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mem_sequencer
// Purpose  : Self-checking bench. Two sequencers (MEM_LAT 1 and 3) share the
//            control stimulus; each has its own memory and ALU model. Stimulus
//            pushes expected memory writes into per-lane queues; a monitor pops
//            and compares whenever a lane presents mem_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mem_sequencer;

  localparam int N    = 25;
  localparam int DW   = 8;
  localparam int AW   = 7;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        op_code;

  logic              busy [2];
  logic              done [2];
  logic              error [2];
  logic              overflow [2];
  logic [AW-1:0]     mem_addr [2];
  logic              mem_we [2];
  logic [15:0]       mem_wdata [2];
  logic [15:0]       mem_rdata [2];
  logic [2:0]        alu_op [2];
  logic [N*DW-1:0]   alu_a [2];
  logic [N*DW-1:0]   alu_b [2];
  logic              alu_start [2];
  logic              alu_done [2];
  logic              alu_overflow [2];
  logic [N*DW-1:0]   alu_result [2];

  logic [15:0]       mem [2][128];
  logic [15:0]       rpipe [2][4];
  int                alu_cnt [2];
  int                alu_mode;   // 0: A+B, 1: 8'h7F with overflow, 2: never done
  int                init_req;   // 0: none, 1: load sources, 2: sentinel dst

  wr_t               exp_q [2][$];
  wr_t               e;
  int                done_cnt [2];
  int                wr_cnt [2];
  int                len_cnt [2];
  int                read_len [2];
  logic [7:0]        a24_snap [2];
  logic [7:0]        b24_snap [2];

  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    matrix_mem_sequencer #(
      .DATA_W   (DW),
      .DIM      (5),
      .ADDR_W   (AW),
      .MEM_LAT  ((g == 0) ? LAT0 : LAT1),
      .SRC_BASE (0),
      .DST_BASE (25),
      .TIMEOUT  (10)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op_code      (op_code),
      .busy         (busy[g]),
      .done         (done[g]),
      .error        (error[g]),
      .overflow     (overflow[g]),
      .mem_addr     (mem_addr[g]),
      .mem_we       (mem_we[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g]),
      .alu_op       (alu_op[g]),
      .alu_a        (alu_a[g]),
      .alu_b        (alu_b[g]),
      .alu_start    (alu_start[g]),
      .alu_done     (alu_done[g]),
      .alu_overflow (alu_overflow[g]),
      .alu_result   (alu_result[g])
    );
  end

  // ALU result model and memory read port
  always_comb begin
    mem_rdata[0] = rpipe[0][LAT0-1];
    mem_rdata[1] = rpipe[1][LAT1-1];
    for (int g = 0; g < 2; g++) begin
      alu_overflow[g] = (alu_mode == 1);
      for (int k = 0; k < N; k++)
        alu_result[g][k*DW +: DW] = (alu_mode == 1) ? 8'h7F :
                                    alu_a[g][k*DW +: DW] + alu_b[g][k*DW +: DW];
    end
  end

  // Memories, read pipelines and ALU done timing (done 3 cycles after start)
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_we[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
      rpipe[g][0] <= mem[g][mem_addr[g]];
      for (int s = 1; s < 4; s++) rpipe[g][s] <= rpipe[g][s-1];
      if (reset) begin
        alu_cnt[g]  <= 0;
        alu_done[g] <= 1'b0;
      end else begin
        if (alu_start[g])        alu_cnt[g] <= 2;
        else if (alu_cnt[g] != 0) alu_cnt[g] <= alu_cnt[g] - 1;
        alu_done[g] <= (alu_cnt[g] == 1) && (alu_mode != 2);
      end
    end
    if (init_req == 1) begin
      for (int g = 0; g < 2; g++)
        for (int k = 0; k < N; k++) mem[g][k] <= {8'h01, 8'(k + 1)};
    end else if (init_req == 2) begin
      for (int g = 0; g < 2; g++)
        for (int k = 25; k < 50; k++) mem[g][k] <= 16'hA5A5;
    end
  end

  // Monitor: write scoreboard, done pulses, READ length and operand snapshot
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_we[g]) begin
        wr_cnt[g]++;
        tests++;
        if (exp_q[g].size() == 0) begin
          fails++;
          $display("FAIL lane%0d write: got addr=%0d data=%h, required no write",
                   g, mem_addr[g], mem_wdata[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (mem_addr[g] !== e.addr || mem_wdata[g] !== e.data) begin
            fails++;
            $display("FAIL lane%0d write: got addr=%0d data=%h, required addr=%0d data=%h",
                     g, mem_addr[g], mem_wdata[g], e.addr, e.data);
          end
        end
      end
      if (done[g]) done_cnt[g]++;
      if (!busy[g]) begin
        len_cnt[g] = 0;
      end else begin
        if (alu_start[g]) begin
          read_len[g] = len_cnt[g];
          a24_snap[g] = alu_a[g][24*DW +: DW];
          b24_snap[g] = alu_b[g][24*DW +: DW];
        end
        len_cnt[g]++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push_writes(input int g, input int count, input bit sat);
    wr_t w;
    for (int i = 0; i < count; i++) begin
      w.addr = AW'(25 + (i % N));
      w.data = sat ? 16'h007F : 16'((i % N) + 2);
      exp_q[g].push_back(w);
    end
  endtask

  task automatic do_start(input logic [2:0] op);
    @(negedge clk);
    op_code = op;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    op_code = ~op;
  endtask

  task automatic wait_done(input int t0, input int t1, input int budget);
    int n = 0;
    while ((done_cnt[0] < t0 || done_cnt[1] < t1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt[0] < t0 || done_cnt[1] < t1) begin
      fails++;
      $display("FAIL wait_done: got done counts %0d/%0d, required %0d/%0d within %0d cycles",
               done_cnt[0], done_cnt[1], t0, t1, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int seen;
    reset    = 1'b1;
    start    = 1'b0;
    op_code  = 3'd0;
    alu_mode = 0;
    init_req = 0;
    for (int g = 0; g < 2; g++) begin
      done_cnt[g] = 0; wr_cnt[g] = 0; len_cnt[g] = 0; read_len[g] = 0;
    end
    repeat (3) @(negedge clk);
    init_req = 1;
    @(negedge clk);
    init_req = 0;

    // Reset state
    chk("reset busy",      busy[0],      0);
    chk("reset done",      done[0],      0);
    chk("reset mem_we",    mem_we[0],    0);
    chk("reset alu_start", alu_start[0], 0);
    chk("reset overflow",  overflow[1],  0);
    chk("reset error",     error[1],     0);
    chk("reset mem_addr",  mem_addr[0],  0);
    chk("reset alu_a[0]",  alu_a[0][31:0], 0);
    chk("reset alu_op",    alu_op[1],    0);
    reset = 1'b0;

    // Normal operation: result = A + B = (k+1) + 1
    push_writes(0, N, 1'b0);
    push_writes(1, N, 1'b0);
    do_start(3'd5);
    chk("alu_op latched", alu_op[0], 5);
    wait_done(1, 1, 300);
    chk("op1 lane0 queue drained", exp_q[0].size(), 0);
    chk("op1 lane1 queue drained", exp_q[1].size(), 0);
    chk("op1 lane0 write count",   wr_cnt[0], 25);
    chk("op1 lane1 write count",   wr_cnt[1], 25);
    chk("op1 lane0 done pulses",   done_cnt[0], 1);
    chk("op1 lane0 READ length",   read_len[0], 26);
    chk("op1 lane1 READ length",   read_len[1], 28);
    chk("op1 lane1 alu_a[24]",     a24_snap[1], 25);
    chk("op1 lane1 alu_b[24]",     b24_snap[1], 1);
    chk("op1 lane0 alu_a[0] held", alu_a[0][7:0], 1);
    chk("op1 lane0 overflow",      overflow[0], 0);
    chk("op1 lane0 busy after",    busy[0], 0);

    // ALU reports overflow with saturated values
    alu_mode = 1;
    push_writes(0, N, 1'b1);
    push_writes(1, N, 1'b1);
    do_start(3'd2);
    wait_done(2, 2, 300);
    chk("ovf lane0 overflow set", overflow[0], 1);
    chk("ovf lane1 overflow set", overflow[1], 1);
    chk("ovf lane1 queue drained", exp_q[1].size(), 0);

    // Overflow clears at the next accepted start
    alu_mode = 0;
    push_writes(0, N, 1'b0);
    push_writes(1, N, 1'b0);
    do_start(3'd1);
    chk("clr lane0 overflow cleared", overflow[0], 0);
    chk("clr lane1 overflow cleared", overflow[1], 0);
    chk("clr lane0 busy", busy[0], 1);
    wait_done(3, 3, 300);

    // start held for 200 cycles: accepts at IDLE edges 1,58,115,172 (lane0)
    // and 1,60,119,178 (lane1) -> four operations each
    push_writes(0, 4 * N, 1'b0);
    push_writes(1, 4 * N, 1'b0);
    @(negedge clk);
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    wait_done(7, 7, 400);
    repeat (80) @(negedge clk);
    chk("held lane0 done pulses", done_cnt[0], 7);
    chk("held lane1 done pulses", done_cnt[1], 7);
    chk("held lane0 write count", wr_cnt[0], 175);
    chk("held lane1 queue drained", exp_q[1].size(), 0);
    chk("held lane0 idle", busy[0], 0);

    // Reset in lane0's 10th WRITE cycle; lane1 is two cycles behind (8 writes)
    init_req = 2;
    @(negedge clk);
    init_req = 0;
    push_writes(0, 10, 1'b0);
    push_writes(1, 8, 1'b0);
    do_start(3'd3);
    seen = 0;
    for (int n = 0; n < 300 && seen < 10; n++) begin
      @(negedge clk);
      if (mem_we[0]) seen++;
    end
    chk("rst lane0 reached 10th write", seen, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst lane0 mem_we",  mem_we[0], 0);
    chk("rst lane1 mem_we",  mem_we[1], 0);
    chk("rst lane0 busy",    busy[0],   0);
    chk("rst lane1 alu_a",   alu_a[1][31:0], 0);
    repeat (5) @(negedge clk);
    chk("rst lane0 queue drained", exp_q[0].size(), 0);
    chk("rst lane1 queue drained", exp_q[1].size(), 0);
    chk("rst lane0 mem[34]", mem[0][34], 16'h000B);
    bad = 0;
    for (int a = 35; a < 50; a++) if (mem[0][a] !== 16'hA5A5) bad++;
    chk("rst lane0 mem[35..49] untouched", bad, 0);
    bad = 0;
    for (int a = 33; a < 50; a++) if (mem[1][a] !== 16'hA5A5) bad++;
    chk("rst lane1 mem[33..49] untouched", bad, 0);

`ifdef MATSEQ_TIMEOUT_EN
    // ALU never answers: error, done pulse, no writes
    alu_mode = 2;
    do_start(3'd4);
    wait_done(8, 8, 200);
    chk("to lane0 error", error[0], 1);
    chk("to lane1 error", error[1], 1);
    chk("to lane0 no writes", wr_cnt[0], 185);
`else
    chk("final lane0 error tied low", error[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
